// File: rtl/ddr3_rw_arbiter.sv
// ddr3_rw_arbiter
// Shares the DDR3 application interface between the frame-buffer write path
// (pixel ingress FIFO) and the read path (scan-out FIFO). It grants one
// fixed-length burst at a time and keeps a linear frame address per channel
// that wraps at MAX_ADDR. It runs entirely in the memory_clk_div4 domain.
//
// Optional feature, enabled by defining ARB_PING_PONG_EN:
//   There are two frame buffers, at base 0 and at FRAME_OFFSET. The write bank
//   toggles on every frame restart of the write path. A read frame restart
//   selects the bank that is not currently being written.
//   When ARB_PING_PONG_EN is not defined, a single buffer at base 0 is used.
module ddr3_rw_arbiter #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WD    = 16,
  parameter int BURST_LEN  = 64,
  parameter int MAX_ADDR   = 172800
`ifdef ARB_PING_PONG_EN
  ,
  parameter logic [ADDR_WIDTH-1:0] FRAME_OFFSET = ADDR_WIDTH'(27'h0100000)
`endif
) (
  input  logic                  ref_clk,
  input  logic                  rst,
  input  logic                  init_done,
  input  logic                  wr_load,
  input  logic                  rd_load,
  input  logic                  wr_req,
  input  logic [127:0]          wr_fifo_data,
  output logic                  wr_fifo_rd_en,
  input  logic                  rd_req,
  input  logic                  rd_urgent,
  output logic                  rd_fifo_wr_en,
  output logic [127:0]          rd_fifo_data,
  output logic [2:0]            cmd,
  output logic                  cmd_en,
  input  logic                  cmd_rdy,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [127:0]          ddr3_wr_data,
  input  logic                  ddr3_wr_rdy,
  output logic                  ddr3_wren,
  output logic                  ddr3_wr_end,
  input  logic [127:0]          ddr3_rd_data,
  input  logic                  ddr3_rd_valid,
  output logic                  busy
);

  // 128-bit beats per burst; the beat counter must hold at least one bit.
  localparam int BEATS = (BURST_LEN * DATA_WD) / 128;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CMD,
    ST_WR_DATA,
    ST_RD_CMD,
    ST_RD_WAIT
  } state_e;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

  // This is the next burst address in a frame. It returns to 0 once the next
  // burst would start at or beyond the end of the frame.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] sum;
    sum = {1'b0, a} + (ADDR_WIDTH + 1)'(BURST_LEN);
    if (sum >= (ADDR_WIDTH + 1)'(MAX_ADDR)) begin
      return '0;
    end
    return sum[ADDR_WIDTH-1:0];
  endfunction

  state_e                  state_q, state_d;
  grant_e                  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]        beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    wr_pend_q, wr_pend_d;
  logic                    rd_pend_q, rd_pend_d;
  logic                    rd_fifo_wr_en_q;
  logic [127:0]            rd_fifo_data_q;

  logic                    wr_done, rd_done;
  logic                    wr_active, rd_active;
  logic                    wr_restart, rd_restart;
  logic [ADDR_WIDTH-1:0]   wr_base, rd_base;

`ifdef ARB_PING_PONG_EN
  logic wr_bank_q, wr_bank_d;
  logic rd_bank_q, rd_bank_d;

  assign wr_base = wr_bank_q ? FRAME_OFFSET : '0;
  assign rd_base = rd_bank_q ? FRAME_OFFSET : '0;
`else
  assign wr_base = '0;
  assign rd_base = '0;
`endif

  // A channel counts as being mid-burst from command issue until its last beat.
  assign wr_active = (state_q == ST_WR_CMD) || (state_q == ST_WR_DATA);
  assign rd_active = (state_q == ST_RD_CMD) || (state_q == ST_RD_WAIT);

  assign busy          = (state_q != ST_IDLE);
  assign rd_fifo_wr_en = rd_fifo_wr_en_q;
  assign rd_fifo_data  = rd_fifo_data_q;

  // Arbitration, burst sequencing and the DDR3 command/data strobes.
  always_comb begin
    // NOTE: every signal gets a default before the case; otherwise any path
    // that skips an assignment would infer a latch.
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    beat_d        = beat_q;
    wr_done       = 1'b0;
    rd_done       = 1'b0;
    cmd           = CMD_WR;
    cmd_en        = 1'b0;
    addr          = '0;
    ddr3_wren     = 1'b0;
    ddr3_wr_end   = 1'b0;
    ddr3_wr_data  = '0;
    wr_fifo_rd_en = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (init_done) begin
          if (rd_urgent && rd_req) begin
            state_d      = ST_RD_CMD;
            last_grant_d = GRANT_RD;
          end else if (wr_req && rd_req) begin
            if (last_grant_q == GRANT_RD) begin
              state_d      = ST_WR_CMD;
              last_grant_d = GRANT_WR;
            end else begin
              state_d      = ST_RD_CMD;
              last_grant_d = GRANT_RD;
            end
          end else if (wr_req) begin
            state_d      = ST_WR_CMD;
            last_grant_d = GRANT_WR;
          end else if (rd_req) begin
            state_d      = ST_RD_CMD;
            last_grant_d = GRANT_RD;
          end
        end
      end

      ST_WR_CMD: begin
        cmd    = CMD_WR;
        cmd_en = 1'b1;
        addr   = wr_base + wr_addr_q;
        if (cmd_rdy) begin
          state_d = ST_WR_DATA;
        end
      end

      ST_WR_DATA: begin
        ddr3_wr_data  = wr_fifo_data;
        ddr3_wren     = ddr3_wr_rdy;
        wr_fifo_rd_en = ddr3_wr_rdy;
        if (ddr3_wr_rdy) begin
          if (beat_q == LAST_BEAT) begin
            ddr3_wr_end = 1'b1;
            wr_done     = 1'b1;
            beat_d      = '0;
            state_d     = ST_IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      ST_RD_CMD: begin
        cmd    = CMD_RD;
        cmd_en = 1'b1;
        addr   = rd_base + rd_addr_q;
        if (cmd_rdy) begin
          state_d = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        if (ddr3_rd_valid) begin
          if (beat_q == LAST_BEAT) begin
            rd_done = 1'b1;
            beat_d  = '0;
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Frame-address bookkeeping. A load pulse outside a burst restarts the
  // address at once, so a grant in the same cycle already issues address 0.
  // A load pulse during a burst is held until that burst finishes at its
  // original address.
  always_comb begin
    wr_restart = (wr_load && !wr_active) || (wr_done && (wr_pend_q || wr_load));
    rd_restart = (rd_load && !rd_active) || (rd_done && (rd_pend_q || rd_load));

    wr_addr_d = wr_addr_q;
    if (wr_restart) begin
      wr_addr_d = '0;
    end else if (wr_done) begin
      wr_addr_d = next_addr(wr_addr_q);
    end

    rd_addr_d = rd_addr_q;
    if (rd_restart) begin
      rd_addr_d = '0;
    end else if (rd_done) begin
      rd_addr_d = next_addr(rd_addr_q);
    end

    wr_pend_d = wr_done ? 1'b0 : (wr_pend_q || (wr_load && wr_active));
    rd_pend_d = rd_done ? 1'b0 : (rd_pend_q || (rd_load && rd_active));

`ifdef ARB_PING_PONG_EN
    wr_bank_d = wr_restart ? ~wr_bank_q : wr_bank_q;
    rd_bank_d = rd_restart ? ~wr_bank_q : rd_bank_q;
`endif
  end

  // State registers, plus a one-cycle forwarding stage from DDR3 reads to the read FIFO.
  always_ff @(posedge ref_clk) begin
    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    if (rst) begin
      state_q         <= ST_IDLE;
      last_grant_q    <= GRANT_RD;
      beat_q          <= '0;
      wr_addr_q       <= '0;
      rd_addr_q       <= '0;
      wr_pend_q       <= 1'b0;
      rd_pend_q       <= 1'b0;
      rd_fifo_wr_en_q <= 1'b0;
      rd_fifo_data_q  <= '0;
`ifdef ARB_PING_PONG_EN
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      beat_q          <= beat_d;
      wr_addr_q       <= wr_addr_d;
      rd_addr_q       <= rd_addr_d;
      wr_pend_q       <= wr_pend_d;
      rd_pend_q       <= rd_pend_d;
      rd_fifo_wr_en_q <= ddr3_rd_valid;
      rd_fifo_data_q  <= ddr3_rd_data;
`ifdef ARB_PING_PONG_EN
      wr_bank_q       <= wr_bank_d;
      rd_bank_q       <= rd_bank_d;
`endif
    end
  end

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// tb_ddr3_rw_arbiter
// This is a scoreboard bench for ddr3_rw_arbiter.
// The driver pushes each burst command it expects, in order.
// A responder models the DDR3 read-data return and the write-ready gaps.
// It also pushes every read beat it produces.
// A monitor sampling on the falling edge pops both queues and compares
// them with what the DUT presents.
module tb_ddr3_rw_arbiter;

  localparam int AW = 27;

  typedef struct {
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
  } cmd_t;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } rd_beat_t;

  logic          ref_clk = 1'b0;
  logic          rst;
  logic          init_done;
  logic          wr_load;
  logic          rd_load;
  logic          wr_req;
  logic [127:0]  wr_fifo_data;
  logic          wr_fifo_rd_en;
  logic          rd_req;
  logic          rd_urgent;
  logic          rd_fifo_wr_en;
  logic [127:0]  rd_fifo_data;
  logic [2:0]    cmd;
  logic          cmd_en;
  logic          cmd_rdy;
  logic [AW-1:0] addr;
  logic [127:0]  ddr3_wr_data;
  logic          ddr3_wr_rdy;
  logic          ddr3_wren;
  logic          ddr3_wr_end;
  logic [127:0]  ddr3_rd_data;
  logic          ddr3_rd_valid;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  cmd_t     exp_cmd[$];
  rd_beat_t exp_rd[$];

  // The monitor owns these variables.
  int n_acc        = 0;
  int rd_acc       = 0;
  int wbeat        = 0;
  int wbeats_total = 0;
  bit wr_phase     = 1'b0;

  // The responder owns this counter; the driver owns gap_en.
  int rd_sent = 0;
  bit gap_en  = 1'b0;

  int          cyc     = 0;
  logic [31:0] pop_cnt = '0;
  int          acc_target = 0;

  always #5 ref_clk = ~ref_clk;

  always @(posedge ref_clk) cyc <= cyc + 1;

  // The write FIFO model: the head word encodes how many words have been popped.
  always @(posedge ref_clk) if (wr_fifo_rd_en === 1'b1) pop_cnt <= pop_cnt + 1;
  assign wr_fifo_data = {4{pop_cnt ^ 32'h5A5A_0000}};

  ddr3_rw_arbiter dut (
    .ref_clk       (ref_clk),
    .rst           (rst),
    .init_done     (init_done),
    .wr_load       (wr_load),
    .rd_load       (rd_load),
    .wr_req        (wr_req),
    .wr_fifo_data  (wr_fifo_data),
    .wr_fifo_rd_en (wr_fifo_rd_en),
    .rd_req        (rd_req),
    .rd_urgent     (rd_urgent),
    .rd_fifo_wr_en (rd_fifo_wr_en),
    .rd_fifo_data  (rd_fifo_data),
    .cmd           (cmd),
    .cmd_en        (cmd_en),
    .cmd_rdy       (cmd_rdy),
    .addr          (addr),
    .ddr3_wr_data  (ddr3_wr_data),
    .ddr3_wr_rdy   (ddr3_wr_rdy),
    .ddr3_wren     (ddr3_wren),
    .ddr3_wr_end   (ddr3_wr_end),
    .ddr3_rd_data  (ddr3_rd_data),
    .ddr3_rd_valid (ddr3_rd_valid),
    .busy          (busy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_cmd(input logic [2:0] c, input int a);
    exp_cmd.push_back('{cmd: c, addr: AW'(a)});
  endtask

  task automatic wait_acc(input int target, input int budget);
    int n = 0;
    while (n_acc < target && n < budget) begin
      @(negedge ref_clk);
      #1;
      n++;
    end
    check("accepts_reached", n_acc, target);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge ref_clk);
      n++;
    end
    check("idle_reached", busy, 1'b0);
  endtask

  // DDR3 model: write-ready gaps, and 8 read beats returned for each accepted read.
  initial begin
    ddr3_rd_valid = 1'b0;
    ddr3_rd_data  = '0;
    ddr3_wr_rdy   = 1'b1;
    forever begin
      @(posedge ref_clk);
      #1;
      ddr3_wr_rdy = gap_en ? ((cyc % 3) != 1) : 1'b1;
      if ((rd_sent < 8 * rd_acc) && ((cyc % 4) != 2)) begin
        ddr3_rd_valid = 1'b1;
        ddr3_rd_data  = {4{32'(rd_sent) ^ 32'hC3C3_0000}};
        exp_rd.push_back('{data: ddr3_rd_data, cyc: cyc});
        rd_sent++;
      end else begin
        ddr3_rd_valid = 1'b0;
      end
    end
  end

  // Monitor: it checks command acceptances, write beats and read-FIFO pushes.
  initial begin
    cmd_t     ec;
    rd_beat_t eb;
    forever begin
      @(negedge ref_clk);
      if (rst === 1'b0) begin
        if (cmd_en === 1'b1 && cmd_rdy === 1'b1) begin
          if (exp_cmd.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL cmd_unexpected: got cmd %0h addr %0h, expected no command", cmd, addr);
          end else begin
            ec = exp_cmd.pop_front();
            check("cmd", cmd, ec.cmd);
            check("addr", addr, ec.addr);
          end
          if (cmd == 3'b000) begin
            check("beats_before_wr_cmd", wbeat, 0);
            wr_phase = 1'b1;
          end else begin
            rd_acc++;
          end
          n_acc++;
        end
        if (ddr3_wren === 1'b1) begin
          check("wren_after_cmd", wr_phase, 1'b1);
          check("wr_fifo_rd_en", wr_fifo_rd_en, 1'b1);
          check("wr_data", ddr3_wr_data, {4{32'(wbeats_total) ^ 32'h5A5A_0000}});
          check("wr_end", ddr3_wr_end, (wbeat == 7));
          wbeat++;
          wbeats_total++;
          if (wbeat == 8) begin
            wbeat    = 0;
            wr_phase = 1'b0;
          end
        end else begin
          check("no_pop_without_wren", {ddr3_wr_end, wr_fifo_rd_en}, 2'b00);
        end
        if (rd_fifo_wr_en === 1'b1) begin
          if (exp_rd.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rd_push_unexpected: got data %0h, expected no push", rd_fifo_data);
          end else begin
            eb = exp_rd.pop_front();
            check("rd_fifo_data", rd_fifo_data, eb.data);
            check("rd_push_latency", cyc, eb.cyc + 1);
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish, expected finish before time 600000");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    int n;
    rst       = 1'b1;
    init_done = 1'b0;
    wr_load   = 1'b0;
    rd_load   = 1'b0;
    wr_req    = 1'b0;
    rd_req    = 1'b0;
    rd_urgent = 1'b0;
    cmd_rdy   = 1'b0;

    // Reset holds every output at zero.
    repeat (3) begin
      @(negedge ref_clk);
      check("rst_cmd_en", cmd_en, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_wren", ddr3_wren, 1'b0);
      check("rst_rd_push", rd_fifo_wr_en, 1'b0);
      check("rst_addr", addr, '0);
    end
    @(posedge ref_clk); #1;
    rst    = 1'b0;
    wr_req = 1'b1;
    // While calibration is incomplete, no grant is issued.
    repeat (8) begin
      @(negedge ref_clk);
      check("noinit_cmd_en", cmd_en, 1'b0);
      check("noinit_busy", busy, 1'b0);
    end

    // A single writer, with the command held for 4 cycles by a slow cmd_rdy.
    push_cmd(3'b000, 0);
    push_cmd(3'b000, 64);
    gap_en = 1'b1;
    @(posedge ref_clk); #1;
    init_done = 1'b1;
    n = 0;
    while (cmd_en !== 1'b1 && n < 10) begin
      @(negedge ref_clk);
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge ref_clk);
      check("held_cmd_en", cmd_en, 1'b1);
      check("held_cmd", cmd, 3'b000);
      check("held_addr", addr, '0);
    end
    @(posedge ref_clk); #1;
    cmd_rdy = 1'b1;
    acc_target += 2;
    wait_acc(acc_target, 200);
    wr_req = 1'b0;
    wait_idle(100);
    gap_en = 1'b0;

    // Reset, then both channels request: grants alternate W,R,W,R.
    @(posedge ref_clk); #1;
    rst = 1'b1;
    @(posedge ref_clk); #1;
    rst = 1'b0;
    push_cmd(3'b000, 0);
    push_cmd(3'b001, 0);
    push_cmd(3'b000, 64);
    push_cmd(3'b001, 64);
    wr_req = 1'b1;
    rd_req = 1'b1;
    acc_target += 4;
    wait_acc(acc_target, 300);
    wr_req = 1'b0;
    rd_req = 1'b0;
    wait_idle(100);

    // An urgent read wins every arbitration.
    push_cmd(3'b001, 128);
    push_cmd(3'b001, 192);
    push_cmd(3'b001, 256);
    wr_req    = 1'b1;
    rd_req    = 1'b1;
    rd_urgent = 1'b1;
    acc_target += 3;
    wait_acc(acc_target, 300);
    wr_req    = 1'b0;
    rd_req    = 1'b0;
    rd_urgent = 1'b0;
    wait_idle(100);

    // A load in IDLE, then a full frame of 2700 bursts plus one more that wraps to 0.
    @(posedge ref_clk); #1;
    wr_load = 1'b1;
    @(posedge ref_clk); #1;
    wr_load = 1'b0;
    for (int k = 0; k < 2700; k++) push_cmd(3'b000, k * 64);
    push_cmd(3'b000, 0);
    wr_req = 1'b1;
    acc_target += 2701;
    wait_acc(acc_target, 40000);
    wr_req = 1'b0;
    wait_idle(100);

    // A load during a write burst: the burst finishes at 64, and the next one starts at 0.
    push_cmd(3'b000, 64);
    push_cmd(3'b000, 0);
    wr_req = 1'b1;
    acc_target += 1;
    wait_acc(acc_target, 100);
    @(posedge ref_clk); #1;
    wr_load = 1'b1;
    @(posedge ref_clk); #1;
    wr_load = 1'b0;
    acc_target += 1;
    wait_acc(acc_target, 100);
    wr_req = 1'b0;
    wait_idle(100);

    // init_done falls mid-burst: the burst completes, and then no more grants are issued.
    push_cmd(3'b000, 64);
    wr_req = 1'b1;
    acc_target += 1;
    wait_acc(acc_target, 100);
    @(posedge ref_clk); #1;
    init_done = 1'b0;
    wait_idle(100);
    repeat (10) begin
      @(negedge ref_clk);
      check("init_low_cmd_en", cmd_en, 1'b0);
      check("init_low_busy", busy, 1'b0);
    end
    wr_req    = 1'b0;
    init_done = 1'b1;

    // Reads 0..640, with rd_load during the 640 burst, so the next read is at 0.
    @(posedge ref_clk); #1;
    rd_load = 1'b1;
    @(posedge ref_clk); #1;
    rd_load = 1'b0;
    for (int k = 0; k <= 10; k++) push_cmd(3'b001, k * 64);
    push_cmd(3'b001, 0);
    rd_req = 1'b1;
    acc_target += 11;
    wait_acc(acc_target, 400);
    @(posedge ref_clk); #1;
    rd_load = 1'b1;
    @(posedge ref_clk); #1;
    rd_load = 1'b0;
    acc_target += 1;
    wait_acc(acc_target, 100);
    rd_req = 1'b0;
    wait_idle(100);

    repeat (5) @(negedge ref_clk);
    check("cmd_queue_empty", exp_cmd.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
    check("wr_beat_aligned", wbeat, 0);
    check("rd_beats_returned", rd_sent, 8 * rd_acc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
